fetch_entry_queue: RTL and testbench

//  Elastic buffer between the frontend and id_stage. Accepts fetch_entry_t beats on a valid/ready

---
 rtl/ariane_pkg.sv | 19 +
 rtl/fetch_entry_queue.sv | 112 +++++++++++
 tb/tb_fetch_entry_queue.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared frontend/decode types used by the fetch entry queue.
package ariane_pkg;

  typedef enum logic {RUN, HALT} fq_state_e;

  localparam int FQ_DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [7:0] cause;
    logic       valid;
  } exception_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] instruction;
    exception_t  ex;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_queue.sv
// Elastic in-order buffer between the frontend and the decode stage.
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty and
// running, the incoming entry is forwarded to decode in the same cycle.
//
// state | meaning
// RUN   | accepting entries while space is available
// HALT  | an excepting entry was stored; refuse new entries, keep draining until flush
module fetch_entry_queue
  import ariane_pkg::*;
#(
  parameter int DEPTH       = FQ_DEFAULT_DEPTH,
  parameter int ALMOST_FULL = DEPTH - 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  fetch_entry_t                 fetch_entry_i,
  input  logic                         fetch_valid_i,
  output logic                         fetch_ready_o,
  output fetch_entry_t                 fetch_entry_o,
  output logic                         fetch_valid_o,
  input  logic                         fetch_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o,
  output logic                         almost_full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL);

  fetch_entry_t         mem_q [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]     count_q;
  fq_state_e            state_q, state_d;

  logic bypass;
  logic push, pop;
  logic bypass_take;
  logic wr_en, rd_en;

  // Bypass is only possible on an empty, running queue outside a flush.
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && (state_q == RUN) && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  // Handshake outputs and the entry presented to decode.
  always_comb begin
    fetch_ready_o = (state_q == RUN) && (count_q != FULL_CNT) && !flush_i;
    fetch_valid_o = (count_q != '0) && !flush_i;
    fetch_entry_o = mem_q[rd_ptr_q];
    if (bypass) begin
      fetch_valid_o = fetch_valid_i;
      fetch_entry_o = fetch_entry_i;
    end
  end

  assign push        = fetch_valid_i && fetch_ready_o;
  assign pop         = fetch_valid_o && fetch_ready_i;
  // A bypassed beat that decode takes immediately never touches storage.
  assign bypass_take = bypass && pop;
  assign wr_en       = push && !bypass_take;
  assign rd_en       = pop && !bypass_take;

  assign usage_o       = count_q;
  assign almost_full_o = (count_q >= AF_CNT);

  // Next-state logic: halt on an accepted excepting entry, resume only on flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (push && fetch_entry_i.ex.valid) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    if (flush_i) state_d = RUN;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Storage, pointers and occupancy; flush drops everything without a transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= fetch_entry_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Self-checking bench for fetch_entry_queue (DEPTH=4): vector table plus
// scoreboard of accepted entries compared against what decode receives.
module tb_fetch_entry_queue;
  import ariane_pkg::*;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         flush_i;
  fetch_entry_t fetch_entry_i;
  logic         fetch_valid_i;
  logic         fetch_ready_o;
  fetch_entry_t fetch_entry_o;
  logic         fetch_valid_o;
  logic         fetch_ready_i;
  logic [2:0]   usage_o;
  logic         almost_full_o;

  fetch_entry_queue #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .fetch_entry_i(fetch_entry_i), .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_entry_o(fetch_entry_o), .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i),
    .usage_o(usage_o), .almost_full_o(almost_full_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  fetch_entry_t sb[$];

  typedef struct {
    logic        v, r, f, ex;
    logic [31:0] id;
    logic        e_rdy, e_vld;
    logic [2:0]  e_use;
    logic        e_af;
    logic        byp;
  } vec_t;

  vec_t tbl[19];

  function automatic fetch_entry_t mk(input logic [31:0] id, input logic ex);
    fetch_entry_t e;
    e.address     = {id[29:0], 2'b00};
    e.instruction = id;
    e.ex.cause    = ex ? 8'd2 : 8'd0;
    e.ex.valid    = ex;
    return e;
  endfunction

  function automatic vec_t mv(input logic v, r, f, ex, input logic [31:0] id,
                              input logic e_rdy, e_vld, input logic [2:0] e_use,
                              input logic e_af, byp);
    vec_t t;
    t.v = v; t.r = r; t.f = f; t.ex = ex; t.id = id;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_use = e_use; t.e_af = e_af; t.byp = byp;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_entry(input string name, input fetch_entry_t act, input fetch_entry_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, sample outputs at negedge, update the scoreboard.
  task automatic step(input logic v, r, f, input fetch_entry_t e,
                      output logic s_rdy, s_vld, output logic [2:0] s_use,
                      output logic s_af, pushed, popped);
    fetch_valid_i = v; fetch_ready_i = r; flush_i = f; fetch_entry_i = e;
    @(negedge clk_i);
    s_rdy = fetch_ready_o; s_vld = fetch_valid_o; s_use = usage_o; s_af = almost_full_o;
    pushed = v && fetch_ready_o;
    popped = fetch_valid_o && r;
    if (pushed) sb.push_back(e);
    if (fetch_valid_o) begin
      if (sb.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL sb_empty: valid entry %h with nothing expected", fetch_entry_o);
      end else chk_entry("entry_o", fetch_entry_o, sb[0]);
    end
    if (popped && sb.size() > 0) void'(sb.pop_front());
    if (f) sb.delete();
    @(posedge clk_i); #1;
  endtask

  logic s_rdy, s_vld, s_af, pushed, popped;
  logic [2:0] s_use;
  int sent, got;

  initial begin
    // rows: v r f ex id | ready valid usage af | bypass-eligible
    tbl[0]  = mv(1,0,0,0, 1, 1,0,0,0, 1);   // push A
    tbl[1]  = mv(1,0,0,0, 2, 1,1,1,0, 0);   // push B
    tbl[2]  = mv(1,0,0,0, 3, 1,1,2,0, 0);   // push C
    tbl[3]  = mv(0,0,0,0, 0, 1,1,3,1, 0);   // usage 3, almost full, head A
    tbl[4]  = mv(1,0,0,0, 4, 1,1,3,1, 0);   // push D -> full
    tbl[5]  = mv(1,1,0,0, 5, 0,1,4,1, 0);   // full: no push, pop A
    tbl[6]  = mv(0,0,0,0, 0, 1,1,3,1, 0);
    tbl[7]  = mv(1,0,0,1, 6, 1,1,3,1, 0);   // push excepting E
    tbl[8]  = mv(1,1,0,0, 7, 0,1,4,1, 0);   // F refused, drain
    tbl[9]  = mv(1,1,0,0, 7, 0,1,3,1, 0);
    tbl[10] = mv(1,1,0,0, 7, 0,1,2,0, 0);
    tbl[11] = mv(1,1,0,0, 7, 0,1,1,0, 0);   // E drains
    tbl[12] = mv(1,0,0,0, 7, 0,0,0,0, 0);   // halted and empty
    tbl[13] = mv(0,0,1,0, 0, 0,0,0,0, 0);   // flush
    tbl[14] = mv(0,0,0,0, 0, 1,0,0,0, 1);   // running again
    tbl[15] = mv(1,0,0,0, 8, 1,0,0,0, 1);
    tbl[16] = mv(1,0,0,0, 9, 1,1,1,0, 0);
    tbl[17] = mv(1,1,1,0,10, 0,0,2,0, 0);   // flush beats push and pop
    tbl[18] = mv(0,0,0,0, 0, 1,0,0,0, 1);

    rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; fetch_ready_i = 1'b0;
    fetch_entry_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_valid", 32'(fetch_valid_o), 0);
    chk("rst_ready", 32'(fetch_ready_o), 1);
    chk("rst_usage", 32'(usage_o), 0);
    chk("rst_af", 32'(almost_full_o), 0);
    chk_entry("rst_entry", fetch_entry_o, '0);
    @(posedge clk_i); #1;

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, tbl[i].r, tbl[i].f, mk(tbl[i].id, tbl[i].ex),
           s_rdy, s_vld, s_use, s_af, pushed, popped);
      chk($sformatf("row%0d_ready", i), 32'(s_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d_valid", i), 32'(s_vld),
          32'((BYP && tbl[i].byp) ? tbl[i].v : tbl[i].e_vld));
      chk($sformatf("row%0d_usage", i), 32'(s_use), 32'(tbl[i].e_use));
      chk($sformatf("row%0d_af", i), 32'(s_af), 32'(tbl[i].e_af));
    end

    // Stream 10 entries through with decode ready toggling; order via scoreboard.
    sent = 0; got = 0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      step(sent < 10, c[0], 1'b0, mk(32'(100 + sent), 1'b0),
           s_rdy, s_vld, s_use, s_af, pushed, popped);
      if (pushed) sent++;
      if (popped) got++;
    end
    chk("stream_sent", 32'(sent), 10);
    chk("stream_got", 32'(got), 10);
    chk("stream_sb_empty", 32'(sb.size()), 0);
    chk("stream_usage", 32'(usage_o), 0);

    // Empty queue, push X with decode ready.
    step(1, 1, 0, mk(32'h55, 1'b0), s_rdy, s_vld, s_use, s_af, pushed, popped);
    chk("x_valid_same", 32'(s_vld), 32'(BYP));
    chk("x_usage_same", 32'(s_use), 0);
    step(0, 0, 0, '0, s_rdy, s_vld, s_use, s_af, pushed, popped);
    chk("x_valid_next", 32'(s_vld), 32'(!BYP));
    chk("x_usage_next", 32'(s_use), 32'(!BYP));
    step(0, 1, 0, '0, s_rdy, s_vld, s_use, s_af, pushed, popped);
    chk("x_drained", 32'(sb.size()), 0);

    // Reset in the middle of traffic.
    step(1, 0, 0, mk(32'h20, 1'b0), s_rdy, s_vld, s_use, s_af, pushed, popped);
    step(1, 0, 0, mk(32'h21, 1'b1), s_rdy, s_vld, s_use, s_af, pushed, popped);
    rst_i = 1'b1; fetch_valid_i = 1'b1; fetch_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; fetch_valid_i = 1'b0; fetch_ready_i = 1'b0;
    sb.delete();
    @(negedge clk_i);
    chk("mrst_valid", 32'(fetch_valid_o), 0);
    chk("mrst_ready", 32'(fetch_ready_o), 1);
    chk("mrst_usage", 32'(usage_o), 0);
    chk_entry("mrst_entry", fetch_entry_o, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
